// File: rtl/fetch_line_buffer.sv
// fetch_line_buffer
//
// Instruction-fetch front end between the 64-bit instruction port of the
// tightly-coupled memory and the 32-bit decode interface. It requests whole
// 8-byte lines, counts outstanding responses as credits, and buffers returned
// lines in a small FIFO. Each buffered line is handed to decode as two 32-bit
// instructions. A branch redirect flushes the FIFO, marks responses still owed
// as stale, and restarts fetching at the target line.
//
// Ports
//   clk_i, rst_i           clock (rising edge), synchronous active-low reset
//   branch_request_i/pc_i  redirect fetch to branch_pc_i (bits [1:0] ignored)
//   invalidate_i           raise an instruction-memory invalidate (fence.i)
//   fetch_valid_o/accept_i decode handshake
//   fetch_instr_o/pc_o     instruction word and its PC
//   fetch_fault_o          bus error for this PC (instruction forced to 0)
//   mem_rd_o/mem_pc_o      line fetch request and line-aligned address
//   mem_invalidate_o       invalidate request, held until mem_accept_i
//   mem_accept_i           memory accepts the current request
//   mem_valid_i/error_i    in-order response strobe and error flag
//   mem_inst_i             response line: [31:0] at +0, [63:32] at +4
module fetch_line_buffer #(
  parameter logic [31:0] BOOT_VECTOR = 32'h8000_0000,
  parameter int          DEPTH       = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_request_i,
  input  logic [31:0] branch_pc_i,
  input  logic        invalidate_i,
  output logic        fetch_valid_o,
  input  logic        fetch_accept_i,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic        fetch_fault_o,
  output logic        mem_rd_o,
  output logic [31:0] mem_pc_o,
  output logic        mem_invalidate_o,
  input  logic        mem_accept_i,
  input  logic        mem_valid_i,
  input  logic        mem_error_i,
  input  logic [63:0] mem_inst_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Control state
  logic [28:0]   r_fetch_line;  // next line to request
  logic [28:0]   r_resp_line;   // line the next kept response belongs to
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_half;        // low word of head already consumed
  logic          r_first;       // next kept response is first after redirect/reset
  logic          r_start_bit;   // word offset of the redirect target
  logic          r_inv;

  // Line storage (not reset; qualified by r_count)
  logic [63:0]   r_data   [DEPTH];
  logic [28:0]   r_linepc [DEPTH];
  logic          r_err    [DEPTH];
  logic          r_start  [DEPTH];

  logic [CW-1:0] w_count;
  logic          w_mem_rd;
  logic          w_req_fire;
  logic          w_resp;
  logic          w_drop;
  logic          w_push;
  logic          w_valid;
  logic          w_head_sel;
  logic          w_acc;
  logic          w_pop;
  logic          w_unused;

  assign w_unused = ^branch_pc_i[1:0];

  // Credits are the sum of buffered and outstanding lines; a pop in the same
  // cycle does not free a credit, so the FIFO can never overflow.
  assign w_count    = r_count + r_inflight;
  assign w_mem_rd   = rst_i && (w_count < FULL) && !branch_request_i && !r_inv;
  assign w_req_fire = w_mem_rd && mem_accept_i;
  // Responses with nothing outstanding (e.g. right after reset) are ignored.
  assign w_resp     = mem_valid_i && (r_inflight != '0);
  assign w_drop     = w_resp && (r_discard != '0);
  assign w_push     = w_resp && !w_drop && !branch_request_i;

  assign w_valid    = (r_count != '0);
  assign w_head_sel = r_start[r_rd_ptr] | r_half;
  assign w_acc      = w_valid && fetch_accept_i;
  // An error line yields a single faulting instruction, then is popped.
  assign w_pop      = w_acc && (w_head_sel || r_err[r_rd_ptr]);

  assign mem_rd_o         = w_mem_rd;
  assign mem_pc_o         = {r_fetch_line, 3'b000};
  assign mem_invalidate_o = r_inv;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_fetch_line <= BOOT_VECTOR[31:3];
      r_resp_line  <= BOOT_VECTOR[31:3];
      r_inflight   <= '0;
      r_discard    <= '0;
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_half       <= 1'b0;
      r_first      <= 1'b1;
      r_start_bit  <= BOOT_VECTOR[2];
    end else if (branch_request_i) begin
      // Every response still owed after this cycle belongs to the old path.
      r_inflight   <= r_inflight - CW'(w_resp);
      r_discard    <= r_inflight - CW'(w_resp);
      r_fetch_line <= branch_pc_i[31:3];
      r_resp_line  <= branch_pc_i[31:3];
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_half       <= 1'b0;
      r_first      <= 1'b1;
      r_start_bit  <= branch_pc_i[2];
    end else begin
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_resp);
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_drop) begin
        r_discard <= r_discard - CW'(1);
      end
      if (w_req_fire) begin
        r_fetch_line <= r_fetch_line + 29'd1;
      end
      if (w_push) begin
        r_wr_ptr    <= r_wr_ptr + PW'(1);
        r_resp_line <= r_resp_line + 29'd1;
        r_first     <= 1'b0;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_half   <= 1'b0;
      end else if (w_acc) begin
        r_half <= 1'b1;
      end
    end
  end

  // A new invalidate may be raised in the very cycle the previous one is taken.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_inv <= 1'b0;
    end else begin
      r_inv <= (r_inv && !mem_accept_i) || invalidate_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_data[r_wr_ptr]   <= mem_inst_i;
      r_linepc[r_wr_ptr] <= r_resp_line;
      r_err[r_wr_ptr]    <= mem_error_i;
      r_start[r_wr_ptr]  <= r_first & r_start_bit;
    end
  end

  always_comb begin
    fetch_valid_o = w_valid;
    fetch_fault_o = 1'b0;
    fetch_instr_o = '0;
    // While empty, show the PC that will be delivered next.
    fetch_pc_o    = {r_resp_line, r_first & r_start_bit, 2'b00};
    if (w_valid) begin
      fetch_fault_o = r_err[r_rd_ptr];
      fetch_pc_o    = {r_linepc[r_rd_ptr], w_head_sel, 2'b00};
      if (!r_err[r_rd_ptr]) begin
        fetch_instr_o = w_head_sel ? r_data[r_rd_ptr][63:32] : r_data[r_rd_ptr][31:0];
      end
    end
  end

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Directed bench for fetch_line_buffer: a queue-based memory model returns
// lines whose words are a fixed function of their address, and every
// instruction taken by decode is compared against the expected PC stream.
module tb_fetch_line_buffer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        branch_request_i;
  logic [31:0] branch_pc_i;
  logic        invalidate_i;
  logic        fetch_valid_o;
  logic        fetch_accept_i;
  logic [31:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic        fetch_fault_o;
  logic        mem_rd_o;
  logic [31:0] mem_pc_o;
  logic        mem_invalidate_o;
  logic        mem_accept_i;
  logic        mem_valid_i;
  logic        mem_error_i;
  logic [63:0] mem_inst_i;

  fetch_line_buffer #(.BOOT_VECTOR(32'h8000_0000), .DEPTH(4)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .branch_request_i (branch_request_i),
    .branch_pc_i      (branch_pc_i),
    .invalidate_i     (invalidate_i),
    .fetch_valid_o    (fetch_valid_o),
    .fetch_accept_i   (fetch_accept_i),
    .fetch_instr_o    (fetch_instr_o),
    .fetch_pc_o       (fetch_pc_o),
    .fetch_fault_o    (fetch_fault_o),
    .mem_rd_o         (mem_rd_o),
    .mem_pc_o         (mem_pc_o),
    .mem_invalidate_o (mem_invalidate_o),
    .mem_accept_i     (mem_accept_i),
    .mem_valid_i      (mem_valid_i),
    .mem_error_i      (mem_error_i),
    .mem_inst_i       (mem_inst_i)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_out = 0;
  int          n_fault = 0;
  logic [31:0] exp_pc;
  bit          resp_en;
  bit          err_en;
  logic [31:0] err_line;
  bit          found;
  logic [31:0] q[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample outputs before the edge, then update the memory
  // response for the next cycle (in-order, one response per cycle).
  task automatic tick();
    logic        req;
    logic        exp_f;
    logic [31:0] rpc;
    logic [31:0] rpc2;
    #1;
    req = mem_rd_o && mem_accept_i;
    rpc = mem_pc_o;
    if (fetch_valid_o && fetch_accept_i) begin
      exp_f = err_en && (exp_pc[31:3] == err_line[31:3]);
      chk("out_pc", fetch_pc_o, exp_pc);
      chk("out_instr", fetch_instr_o, exp_f ? 32'h0 : word_at(exp_pc));
      chk("out_fault", 32'(fetch_fault_o), 32'(exp_f));
      n_out++;
      if (exp_f) begin
        n_fault++;
        exp_pc = {exp_pc[31:3] + 29'd1, 3'b000};
      end else begin
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    if (req) q.push_back(rpc);
    if (resp_en && q.size() != 0) begin
      rpc2        = q.pop_front();
      mem_valid_i = 1'b1;
      mem_inst_i  = {word_at(rpc2 + 32'd4), word_at(rpc2)};
      mem_error_i = err_en && (rpc2 == err_line);
    end else begin
      mem_valid_i = 1'b0;
      mem_error_i = 1'b0;
    end
  endtask

  initial begin
    rst_i = 1'b0; branch_request_i = 1'b0; branch_pc_i = '0; invalidate_i = 1'b0;
    fetch_accept_i = 1'b0; mem_accept_i = 1'b1; mem_valid_i = 1'b0;
    mem_error_i = 1'b0; mem_inst_i = '0;
    resp_en = 1'b1; err_en = 1'b0; err_line = 32'h8000_0010; exp_pc = 32'h8000_0000;

    // Reset state
    @(posedge clk); #1;
    tick(); tick();
    #1;
    chk("rst_valid", 32'(fetch_valid_o), 32'd0);
    chk("rst_fault", 32'(fetch_fault_o), 32'd0);
    chk("rst_instr", fetch_instr_o, 32'h0);
    chk("rst_pc", fetch_pc_o, 32'h8000_0000);
    chk("rst_rd", 32'(mem_rd_o), 32'd0);
    chk("rst_inv", 32'(mem_invalidate_o), 32'd0);
    chk("rst_mempc", mem_pc_o, 32'h8000_0000);

    // Streaming after reset release
    rst_i = 1'b1; fetch_accept_i = 1'b1;
    #1;
    chk("first_rd", 32'(mem_rd_o), 32'd1);
    chk("first_addr", mem_pc_o, 32'h8000_0000);
    n_out = 0;
    repeat (12) tick();
    chk("stream_count", n_out, 32'd10);

    // Decode stall: credits fill, requests stop, nothing lost
    fetch_accept_i = 1'b0;
    repeat (20) tick();
    #1;
    chk("stall_rd", 32'(mem_rd_o), 32'd0);
    chk("stall_valid", 32'(fetch_valid_o), 32'd1);
    chk("stall_pc", fetch_pc_o, exp_pc);
    fetch_accept_i = 1'b1; n_out = 0;
    repeat (12) tick();
    chk("drain_count", n_out, 32'd12);

    // Invalidate held while memory refuses for three cycles
    invalidate_i = 1'b1;
    tick();
    invalidate_i = 1'b0; mem_accept_i = 1'b0; n_out = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("inv_hold", 32'(mem_invalidate_o), 32'd1);
      chk("inv_no_rd", 32'(mem_rd_o), 32'd0);
      tick();
    end
    mem_accept_i = 1'b1;
    #1;
    chk("inv_hold4", 32'(mem_invalidate_o), 32'd1);
    chk("inv_no_rd4", 32'(mem_rd_o), 32'd0);
    tick();
    chk("inv_drain", n_out, 32'd4);
    #1;
    chk("inv_clear", 32'(mem_invalidate_o), 32'd0);
    chk("inv_rd_resume", 32'(mem_rd_o), 32'd1);

    // Bus error on line 8000_0010
    err_en = 1'b1; branch_request_i = 1'b1; branch_pc_i = 32'h8000_0000;
    tick();
    branch_request_i = 1'b0; exp_pc = 32'h8000_0000; n_out = 0; n_fault = 0;
    repeat (14) tick();
    chk("err_faults", n_fault, 32'd1);
    chk("err_count", n_out, 32'd12);
    err_en = 1'b0;

    // Redirect together with a response and a decode accept
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_valid_i && fetch_valid_o) found = 1'b1;
      else tick();
    end
    chk("sync_found", 32'(found), 32'd1);
    branch_request_i = 1'b1; branch_pc_i = 32'h8000_0200;
    tick();
    branch_request_i = 1'b0; exp_pc = 32'h8000_0200; n_out = 0;
    #1;
    chk("br_flush_valid", 32'(fetch_valid_o), 32'd0);
    chk("br_rd", 32'(mem_rd_o), 32'd1);
    chk("br_addr", mem_pc_o, 32'h8000_0200);
    repeat (8) tick();
    chk("br_count", n_out, 32'd6);

    // Mid-operation reset, then redirect with two lines in flight
    rst_i = 1'b0; fetch_accept_i = 1'b0; resp_en = 1'b0; q.delete();
    tick(); tick();
    #1;
    chk("rst2_valid", 32'(fetch_valid_o), 32'd0);
    chk("rst2_rd", 32'(mem_rd_o), 32'd0);
    chk("rst2_mempc", mem_pc_o, 32'h8000_0000);
    chk("rst2_pc", fetch_pc_o, 32'h8000_0000);
    rst_i = 1'b1; fetch_accept_i = 1'b1;
    tick(); tick();
    chk("inflight_two", q.size(), 32'd2);
    branch_request_i = 1'b1; branch_pc_i = 32'h8000_0104;
    #1;
    chk("br2_no_rd", 32'(mem_rd_o), 32'd0);
    tick();
    branch_request_i = 1'b0; resp_en = 1'b1; exp_pc = 32'h8000_0104; n_out = 0;
    #1;
    chk("br2_rd", 32'(mem_rd_o), 32'd1);
    chk("br2_addr", mem_pc_o, 32'h8000_0100);
    chk("br2_valid", 32'(fetch_valid_o), 32'd0);
    repeat (10) tick();
    chk("br2_count", n_out, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_line_buffer.md
# fetch_line_buffer

Instruction-fetch front end that drives the 64-bit instruction port of the core's tightly-coupled memory and feeds 32-bit instructions to decode. It issues line-aligned fetch requests, tracks in-flight responses with credits, buffers returned 64-bit lines in a small FIFO, and splits each line into two instructions. On a branch redirect it discards stale responses and restarts at the new PC.

## Interface
- BOOT_VECTOR, 32'h8000_0000, PC fetched first after reset
- DEPTH, 4, line FIFO entries; also the maximum of buffered plus in-flight lines (power of two, ≥2)
---
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-low
- branch_request_i  in  1  redirect fetch this cycle
- branch_pc_i  in  32  redirect target; bits [1:0] ignored
- invalidate_i  in  1  request instruction-memory invalidate (fence.i)
- fetch_valid_o  out  1  instruction available to decode
- fetch_accept_i  in  1  decode takes instruction when fetch_valid_o=1
- fetch_instr_o  out  32  instruction word
- fetch_pc_o  out  32  PC of fetch_instr_o
- fetch_fault_o  out  1  fetch bus error for this PC; instr forced to 0
- mem_rd_o  out  1  fetch request
- mem_pc_o  out  32  request address, always {line[31:3],3'b000}
- mem_invalidate_o  out  1  invalidate request, held until accepted
- mem_accept_i  in  1  memory accepts request this cycle
- mem_valid_i  in  1  response valid (in-order)
- mem_error_i  in  1  response error, qualified by mem_valid_i
- mem_inst_i  in  64  response line; [31:0] = word at +0, [63:32] = word at +4

## Operation
- Registers: fetch_line_q (next line to request), inflight_q, discard_q, FIFO (data, line PC, error, start word), word_sel_q.
- count = FIFO occupancy + inflight_q. mem_rd_o = count < DEPTH && !branch_request_i && !mem_invalidate_o. Same-cycle pops do not free credit.
- On mem_rd_o && mem_accept_i: inflight_q+1, fetch_line_q += 8 (wraps at 2^32).
- On mem_valid_i: inflight_q−1; if discard_q≠0, discard_q−1 and drop response; else push {mem_inst_i, line PC, mem_error_i, start word}.
- Start word: bit 2 of the redirect PC for the first line after a redirect/reset; 0 otherwise.
- Output head entry: fetch_instr_o = word_sel ? data[63:32] : data[31:0]; fetch_pc_o = {linepc[31:3], word_sel, 2'b00}. On a head load, word_sel = start word.
- On accept: word_sel=0 → word_sel=1; word_sel=1 → pop, load next head.
- Error entry: one instruction presented with fetch_fault_o=1 and fetch_instr_o=0; popped on accept.
- Redirect (branch_request_i): FIFO cleared; discard_q = inflight_q − (mem_valid_i ? 1 : 0) + (discard_q≠0 && mem_valid_i ? 0 : 0). This is the count of responses still owed after this cycle, and it overrides any same-cycle push. fetch_line_q = {branch_pc_i[31:3],3'b0}; start word = branch_pc_i[2]. A same-cycle accept completes, but its effect is superseded by the flush.
- invalidate_i sets mem_invalidate_o, which stays high until mem_invalidate_o && mem_accept_i. It blocks new fetches only; buffered lines stay valid.

## Timing
- Reset values: fetch_valid_o=0, fetch_fault_o=0, fetch_instr_o=0, fetch_pc_o=BOOT_VECTOR, mem_rd_o=0 during reset, mem_invalidate_o=0, mem_pc_o={BOOT_VECTOR[31:3],3'b0}, inflight/discard/FIFO empty.
- First request in the first cycle after reset deasserts.
- Redirect in cycle N: no request in N; mem_rd_o=1 at new line in N+1. With 1-cycle memory the response arrives at N+2 and fetch_valid_o=1 at N+3 (FIFO is registered, no bypass).
- fetch_valid_o depends only on registered state, never on fetch_accept_i.
- DEPTH=4 with a 1-cycle memory and decode always accepting sustains one instruction per cycle.
- Full: count==DEPTH → mem_rd_o=0. Empty: fetch_valid_o=0.
- Reset mid-operation clears all state; responses arriving in the cycle after reset are ignored because inflight=0. The bench must not return them.

## Test plan
- Reset then release, memory always accepts with 1-cycle latency, decode accepts → PCs 8000_0000, _0004, _0008… on consecutive cycles after the initial 3-cycle latency.
- Redirect to 8000_0104 with 2 lines in flight → 2 responses dropped; first instr PC 8000_0104 (high word), then 8000_0108.
- Decode stalls for 20 cycles → mem_rd_o drops once count hits 4; no line lost; order preserved after release.
- mem_error_i on line 8000_0010 → one output, PC 8000_0010, fetch_fault_o=1, instr 0; next PC 8000_0018.
- invalidate_i while fetching, with mem_accept_i low for 3 cycles → mem_invalidate_o high for 4 cycles; no mem_rd_o during that time; buffered instructions still drain.
- Redirect in the same cycle as accept and as mem_valid_i → response dropped, next output at the target PC.
